// File: rtl/dff_seq_pkg.sv
// rtl/dff_seq_pkg.sv - shared types and reference rule for the flop-bank self-test sequencer
package dff_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    RISE  = 3'd2,
    FALL  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Which model update applies on the cycle a state is entered.
  typedef enum logic [1:0] {
    PH_NONE  = 2'd0,
    PH_SETUP = 2'd1,
    PH_RISE  = 2'd2,
    PH_FALL  = 2'd3
  } phase_t;

  localparam logic [7:0] ERR_SAT = 8'd255;

  // Next value of one modelled flop; SR dominates, then a matching edge with active enable loads d.
  function automatic logic next_exp_bit(
    input phase_t ph,
    input logic   clk_inv,
    input logic   en_inv,
    input logic   sr_inv,
    input logic   sr_val,
    input logic   d,
    input logic   en,
    input logic   sr,
    input logic   cur
  );
    logic sr_act;
    logic en_act;
    logic edge_hit;
    sr_act   = sr ^ sr_inv;
    en_act   = en ^ en_inv;
    edge_hit = ((ph == PH_RISE) && !clk_inv) || ((ph == PH_FALL) && clk_inv);
    if (ph == PH_NONE) begin
      return cur;
    end
    if (sr_act) begin
      return sr_val;
    end
    if (edge_hit && en_act) begin
      return d;
    end
    return cur;
  endfunction

endpackage

// File: rtl/dff_ref_model.sv
// rtl/dff_ref_model.sv - cycle-accurate expected-value register for the flop bank
module dff_ref_model
  import dff_seq_pkg::*;
#(
  parameter int              N_FF         = 8,
  parameter logic [N_FF-1:0] CLK_INV_MASK = '0,
  parameter logic [N_FF-1:0] EN_INV_MASK  = '0,
  parameter logic [N_FF-1:0] SR_INV_MASK  = '0,
  parameter logic [N_FF-1:0] SR_VAL_MASK  = '0,
  parameter logic [N_FF-1:0] INIT_MASK    = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  phase_t          phase,
  input  logic            d,
  input  logic            en,
  input  logic            sr,
  output logic [N_FF-1:0] exp_q
);

  logic [N_FF-1:0] exp_nxt;

  // Per-flop next expected value for the phase being entered (d/en/sr are the values the bank sees then)
  always_comb begin
    exp_nxt = exp_q;
    for (int i = 0; i < N_FF; i++) begin
      exp_nxt[i] = next_exp_bit(phase, CLK_INV_MASK[i], EN_INV_MASK[i], SR_INV_MASK[i],
                                SR_VAL_MASK[i], d, en, sr, exp_q[i]);
    end
  end

  // Expected state; only reset returns it to the power-up pattern, so it persists across runs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q <= INIT_MASK;
    end else begin
      exp_q <= exp_nxt;
    end
  end

endmodule

// File: rtl/dff_cfg_test_sequencer.sv
// rtl/dff_cfg_test_sequencer.sv - drives a configurable flop bank through a vector run and scores it
module dff_cfg_test_sequencer
  import dff_seq_pkg::*;
#(
  parameter int              N_FF         = 8,
  parameter logic [N_FF-1:0] CLK_INV_MASK = '0,
  parameter logic [N_FF-1:0] EN_INV_MASK  = '0,
  parameter logic [N_FF-1:0] SR_INV_MASK  = '0,
  parameter logic [N_FF-1:0] SR_VAL_MASK  = '0,
  parameter logic [N_FF-1:0] INIT_MASK    = '0,
  parameter int              SETTLE       = 2,
  parameter int              N_VEC        = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            ff_d,
  output logic            ff_en,
  output logic            ff_sr,
  output logic            ff_clk,
  input  logic [N_FF-1:0] ff_q,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [7:0]      err_count,
  output logic [7:0]      first_err_vec,
  output logic [N_FF-1:0] first_err_mask
);

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);
  localparam logic [7:0] LAST_VEC = 8'(N_VEC - 1);

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      cnt;
  logic [7:0]      vec;
  logic [7:0]      vec_nxt;
  logic [2:0]      stim;
  logic [2:0]      stim_nxt;
  phase_t          phase;
  logic [N_FF-1:0] exp_q;
  logic [N_FF-1:0] mism;
  logic            last;
  logic            start_acc;
  logic            cmp_hit;
  logic [7:0]      err_nxt;

  assign stim = {ff_sr, ff_en, ff_d};
  assign last = (cnt == SETTLE_L);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, vector index and the stimulus presented when a vector begins
  always_comb begin
    state_nxt = state;
    vec_nxt   = vec;
    stim_nxt  = stim;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETUP;
          vec_nxt   = '0;
        end
      end
      SETUP: if (last) state_nxt = RISE;
      RISE:  if (last) state_nxt = FALL;
      FALL: begin
        if (last) begin
          if (vec == LAST_VEC) begin
            state_nxt = DONE;
          end else begin
            state_nxt = SETUP;
            vec_nxt   = vec + 8'd1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if ((state_nxt == SETUP) && (state != SETUP)) begin
      stim_nxt = vec_nxt[2:0];
    end
  end

  // Status decode, compare result and model phase for the state being entered
  always_comb begin
    busy      = (state == SETUP) || (state == RISE) || (state == FALL);
    done      = (state == DONE);
    start_acc = (state == IDLE) && start;
    mism      = ff_q ^ exp_q;
    cmp_hit   = busy && last && (mism != '0);
    err_nxt   = (cmp_hit && (err_count != ERR_SAT)) ? err_count + 8'd1 : err_count;
    phase     = PH_NONE;
    if (state_nxt != state) begin
      case (state_nxt)
        SETUP:   phase = PH_SETUP;
        RISE:    phase = PH_RISE;
        FALL:    phase = PH_FALL;
        default: phase = PH_NONE;
      endcase
    end
  end

  // Settle counter, vector counter, registered bank stimulus and the run scoreboard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      vec            <= '0;
      ff_d           <= 1'b0;
      ff_en          <= 1'b0;
      ff_sr          <= 1'b0;
      ff_clk         <= 1'b0;
      err_count      <= '0;
      first_err_vec  <= '0;
      first_err_mask <= '0;
      pass           <= 1'b0;
    end else begin
      cnt                   <= (busy && (state_nxt == state)) ? cnt + 4'd1 : 4'd0;
      vec                   <= vec_nxt;
      {ff_sr, ff_en, ff_d}  <= stim_nxt;
      ff_clk                <= (state_nxt == RISE);
      if (start_acc) begin
        err_count      <= '0;
        first_err_vec  <= '0;
        first_err_mask <= '0;
        pass           <= 1'b0;
      end else begin
        err_count <= err_nxt;
        if (cmp_hit && (err_count == 8'd0)) begin
          first_err_vec  <= vec;
          first_err_mask <= mism;
        end
        if (state_nxt == DONE) begin
          pass <= (err_nxt == 8'd0);
        end
      end
    end
  end

  dff_ref_model #(
    .N_FF         (N_FF),
    .CLK_INV_MASK (CLK_INV_MASK),
    .EN_INV_MASK  (EN_INV_MASK),
    .SR_INV_MASK  (SR_INV_MASK),
    .SR_VAL_MASK  (SR_VAL_MASK),
    .INIT_MASK    (INIT_MASK)
  ) u_model (
    .clk   (clk),
    .rst_n (rst_n),
    .phase (phase),
    .d     (stim_nxt[0]),
    .en    (stim_nxt[1]),
    .sr    (stim_nxt[2]),
    .exp_q (exp_q)
  );

endmodule

// File: tb/tb_dff_cfg_test_sequencer.sv
// tb/tb_dff_cfg_test_sequencer.sv - directed scoreboard bench for the flop-bank self-test sequencer
module tb_dff_cfg_test_sequencer;

  localparam logic [3:0] M_CLK_INV = 4'b1010;
  localparam logic [3:0] M_EN_INV  = 4'b1000;
  localparam logic [3:0] M_SR_INV  = 4'b0001;
  localparam logic [3:0] M_SR_VAL  = 4'b0001;
  localparam logic [3:0] M_INIT    = 4'b0000;
  localparam int M_SETTLE = 2;
  localparam int M_NVEC   = 8;
  localparam int VEC_CYC  = 3 * (M_SETTLE + 1);
  localparam int RUN_LAT  = 1 + M_NVEC * VEC_CYC;
  localparam int SAT_LAT  = 1 + 256 * 3 * 2;

  typedef struct {
    int         lat;
    logic       pass;
    logic [7:0] err;
    logic [7:0] fvec;
    logic [3:0] fmask;
  } exp_t;

  exp_t sb[$];

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       ff_d, ff_en, ff_sr, ff_clk;
  logic [3:0] ff_q;
  logic       busy, done, pass;
  logic [7:0] err_count, first_err_vec;
  logic [3:0] first_err_mask;
  logic [3:0] stuck0;

  logic       start_s;
  logic       s_d, s_en, s_sr, s_clk;
  logic [3:0] s_q;
  logic       busy_s, done_s, pass_s;
  logic [7:0] err_s, fvec_s;
  logic [3:0] fmask_s;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dff_cfg_test_sequencer #(
    .N_FF(4), .CLK_INV_MASK(M_CLK_INV), .EN_INV_MASK(M_EN_INV), .SR_INV_MASK(M_SR_INV),
    .SR_VAL_MASK(M_SR_VAL), .INIT_MASK(M_INIT), .SETTLE(M_SETTLE), .N_VEC(M_NVEC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ff_d(ff_d), .ff_en(ff_en), .ff_sr(ff_sr),
    .ff_clk(ff_clk), .ff_q(ff_q), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_vec(first_err_vec), .first_err_mask(first_err_mask)
  );

  dff_cfg_test_sequencer #(
    .N_FF(4), .CLK_INV_MASK(4'b0000), .EN_INV_MASK(4'b0000), .SR_INV_MASK(4'b0000),
    .SR_VAL_MASK(4'b0000), .INIT_MASK(4'b0000), .SETTLE(1), .N_VEC(256)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .ff_d(s_d), .ff_en(s_en), .ff_sr(s_sr),
    .ff_clk(s_clk), .ff_q(s_q), .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_count(err_s), .first_err_vec(fvec_s), .first_err_mask(fmask_s)
  );

  // Behavioural flop bank: async SR, edge capture on the configured ff_clk polarity
  logic [3:0] bq;
  logic       bprev;
  always @(ff_clk or ff_sr or ff_en or ff_d or rst_n) begin
    if (!rst_n) begin
      bq    = M_INIT;
      bprev = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (ff_sr ^ M_SR_INV[i]) bq[i] = M_SR_VAL[i];
        else if ((ff_clk != bprev) && (ff_clk ^ M_CLK_INV[i]) && (ff_en ^ M_EN_INV[i])) bq[i] = ff_d;
      end
      bprev = ff_clk;
    end
  end
  assign ff_q = bq & ~stuck0;

  // Plain bank for the saturation instance, read back inverted so every compare mismatches
  logic [3:0] sq;
  always @(posedge s_clk or posedge s_sr or negedge rst_n) begin
    if (!rst_n) sq <= 4'b0000;
    else if (s_sr) sq <= 4'b0000;
    else if (s_en) sq <= {4{s_d}};
  end
  assign s_q = ~sq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  task automatic check_wave(input string tag, input int n);
    int k, v, ph;
    k  = n - 1;
    v  = k / VEC_CYC;
    ph = (k % VEC_CYC) / (M_SETTLE + 1);
    check({tag, "_ff_clk"}, ff_clk, (ph == 1));
    check({tag, "_stim"}, {ff_sr, ff_en, ff_d}, v[2:0]);
    check({tag, "_busy"}, busy, 1);
  endtask

  task automatic run_main(input string tag, input logic [3:0] stuck, input bit chk_wave,
                          input bit poke, input exp_t e);
    exp_t ep;
    int   n;
    stuck0 = stuck;
    sb.push_back(e);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 1;
    while ((done !== 1'b1) && (n < 4 * RUN_LAT)) begin
      if (chk_wave) check_wave(tag, n);
      if (poke) start = (n == 20);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    ep = sb.pop_front();
    check({tag, "_done"}, done, 1);
    check({tag, "_latency"}, n, ep.lat);
    check({tag, "_pass"}, pass, ep.pass);
    check({tag, "_err_count"}, err_count, ep.err);
    check({tag, "_first_vec"}, first_err_vec, ep.fvec);
    check({tag, "_first_mask"}, first_err_mask, ep.fmask);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    check({tag, "_done_start_ignored"}, busy, 0);
    check({tag, "_done_one_cycle"}, done, 0);
    @(negedge clk);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_hold_err"}, err_count, ep.err);
    check({tag, "_hold_pass"}, pass, ep.pass);
    stuck0 = 4'b0000;
  endtask

  initial begin
    exp_t ep;
    int   n;
    int   k;
    rst_n   = 1'b0;
    start   = 1'b0;
    start_s = 1'b0;
    stuck0  = 4'b0000;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_fvec", first_err_vec, 0);
    check("rst_fmask", first_err_mask, 0);
    check("rst_ff_clk", ff_clk, 0);
    check("rst_stim", {ff_sr, ff_en, ff_d}, 0);
    check("rst_sat_err", err_s, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_main("ideal", 4'b0000, 1'b1, 1'b0, '{RUN_LAT, 1'b1, 8'd0, 8'd0, 4'b0000});
    run_main("stuck2", 4'b0100, 1'b0, 1'b0, '{RUN_LAT, 1'b0, 8'd2, 8'd3, 4'b0100});
    run_main("poke", 4'b0000, 1'b0, 1'b1, '{RUN_LAT, 1'b1, 8'd0, 8'd0, 4'b0000});

    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    k = 0;
    while ((ff_clk !== 1'b1) && (k < 40)) begin
      @(negedge clk);
      k++;
    end
    check("midrst_in_rise", ff_clk, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_ff_clk", ff_clk, 0);
    check("midrst_done", done, 0);
    check("midrst_stim", {ff_sr, ff_en, ff_d}, 0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    run_main("after_rst", 4'b0000, 1'b1, 1'b0, '{RUN_LAT, 1'b1, 8'd0, 8'd0, 4'b0000});

    sb.push_back('{SAT_LAT, 1'b0, 8'd255, 8'd0, 4'b1111});
    @(negedge clk) start_s = 1'b1;
    @(negedge clk) start_s = 1'b0;
    n = 1;
    while ((done_s !== 1'b1) && (n < 2 * SAT_LAT)) begin
      @(negedge clk);
      n++;
    end
    ep = sb.pop_front();
    check("sat_done", done_s, 1);
    check("sat_latency", n, ep.lat);
    check("sat_pass", pass_s, ep.pass);
    check("sat_err_count", err_s, ep.err);
    check("sat_first_vec", fvec_s, ep.fvec);
    check("sat_first_mask", fmask_s, ep.fmask);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
